memaccess_ctrl: RTL and testbench
=================================

MEMACCESS_CTRL -- requirements
Module: memaccess_ctrl

Interface
REQ-001 SHALL have parameter DMEM_LAT, default 1: cycles per memory phase; legal range 1..15.
REQ-002 SHALL have port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: access request, sampled only in IDLE.
REQ-005 SHALL have port op, input, 2: access type sampled with start: 0 direct read (LD/LDR), 1 indirect read (LDI), 2 direct write (ST/STR), 3 indirect write (STI).
REQ-006 SHALL have port memout, input, 16: read data returned by the memory-access datapath.
REQ-007 SHALL have port mem_state, output, 2: datapath state code: 0 READ_MEM, 1 READ_MEM_INDIR, 2 WRITE_MEM, 3 INIT_STATE.
REQ-008 SHALL have port M_Control, output, 1: 1 selects the indirect address (pointer from data memory), 0 selects M_Addr.
REQ-009 SHALL have port busy, output, 1: high while an access is in progress.
REQ-010 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port load_data, output, 16: captured read result.
REQ-012 SHALL have ports rd_count and wr_count, output, 16 each: completed-access counters (see Configuration).

Function
REQ-013 SHALL implement FSM states IDLE, IND, RD and WR; every output SHALL be registered.
REQ-014 SHALL drive mem_state from state: IDLE->3, IND->1, RD->0, WR->2.
REQ-015 SHALL, in IDLE with start=1, latch op and move next cycle to IND for op 1/3, RD for op 0, WR for op 2.
REQ-016 SHALL ignore start outside IDLE: no queuing, latched op unchanged.
REQ-017 SHALL keep each of IND, RD and WR for exactly DMEM_LAT cycles, timed by a 4-bit phase counter cleared on every state entry.
REQ-018 SHALL, at the end of IND, go to RD for latched op 1 or WR for latched op 3.
REQ-019 SHALL, at the end of RD or WR, return to IDLE.
REQ-020 SHALL drive M_Control=1 only in RD or WR of an indirect op, and 0 otherwise, including in IND.
REQ-021 SHALL drive busy=1 in every state except IDLE.
REQ-022 SHALL assert done for exactly one cycle: the last cycle of the final RD or WR phase.
REQ-023 SHALL capture memout into load_data on the clock edge ending the last RD cycle; write ops SHALL leave load_data unchanged.
REQ-024 SHALL give latency, in cycles from the start-sample edge to done: DMEM_LAT for op 0/2, 2*DMEM_LAT for op 1/3.
REQ-025 SHALL make the earliest next start one cycle after done (the IDLE cycle), giving a minimum gap of 1 idle cycle.

Reset
REQ-026 SHALL, with reset=1 at a clock edge, force state IDLE, mem_state=3, M_Control=0, busy=0, done=0, load_data=16'h0000, phase counter 0 and, when compiled in, rd_count=wr_count=0.
REQ-027 SHALL treat reset as taking priority over start and abort any access in progress with no done pulse and no load_data update.

Configuration
REQ-028 SHALL use macro MEMACCESS_CTRL_STATS_EN; when defined, rd_count SHALL increment on each op 0/1 done and wr_count on each op 2/3 done.
REQ-029 SHALL wrap rd_count and wr_count from 16'hFFFF to 16'h0000.
REQ-030 SHALL, when MEMACCESS_CTRL_STATS_EN is undefined, keep rd_count and wr_count ports present, tie them to 16'h0000 and build no counter logic.

Verification
REQ-031 SHALL cover: DMEM_LAT=1, start with op=0 and memout=16'hBEEF -> mem_state 3,0,3, done in cycle 1, load_data=16'hBEEF in cycle 2, M_Control=0 throughout.
REQ-032 SHALL cover: DMEM_LAT=2, op=1, memout=16'h1234 -> mem_state 1,1,0,0, M_Control=1 only in the RD cycles, done in cycle 4, load_data=16'h1234.
REQ-033 SHALL cover: DMEM_LAT=1, op=3 -> mem_state 1 then 2, M_Control=1 in WR, done in cycle 2, load_data unchanged.
REQ-034 SHALL cover: start held high continuously with op=2 and DMEM_LAT=1 -> WR/IDLE alternation, one done per 2 cycles, and start ignored while busy.
REQ-035 SHALL cover: reset asserted in the second IND cycle of an op 1 access with DMEM_LAT=2 -> mem_state=3 and busy=0 next cycle, no done, load_data=0.
REQ-036 SHALL cover, with MEMACCESS_CTRL_STATS_EN defined: preload wr_count to 16'hFFFF, complete one op 2 -> wr_count=16'h0000 and rd_count unchanged.

Source files
------------

// File: rtl/memaccess_ctrl_if.sv
// Request/status bundle between a memory-access requester and memaccess_ctrl.
// master drives the request and read data; slave (the controller) drives status and results.
interface memaccess_ctrl_if;
    logic        start;
    logic [1:0]  op;
    logic [15:0] memout;
    logic [1:0]  mem_state;
    logic        M_Control;
    logic        busy;
    logic        done;
    logic [15:0] load_data;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    modport master (
        output start, op, memout,
        input  mem_state, M_Control, busy, done, load_data, rd_count, wr_count
    );

    modport slave (
        input  start, op, memout,
        output mem_state, M_Control, busy, done, load_data, rd_count, wr_count
    );
endinterface

// File: rtl/memaccess_ctrl.sv
// Sequences direct/indirect loads and stores through IND/RD/WR phases of DMEM_LAT cycles each.
// Optional macro MEMACCESS_CTRL_STATS_EN adds completed read/write counters.
module memaccess_ctrl #(
    parameter int DMEM_LAT = 1
) (
    input logic             clock,
    input logic             reset,
    memaccess_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, IND, RD, WR} state_t;

    localparam logic [3:0] LAST = 4'(DMEM_LAT - 1);

    state_t      state, next_state;
    logic [3:0]  phase, next_phase;
    logic [1:0]  op_q, op_n;
    logic        phase_end;
    logic [1:0]  next_mem_state;
    logic [1:0]  mem_state_q;
    logic        m_control_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] load_data_q;

    // start is only looked at in IDLE, so the latched op cannot change mid-access.
    always_comb begin
        op_n           = op_q;
        next_state     = state;
        phase_end      = (phase == LAST);
        next_mem_state = 2'd3;
        if (state == IDLE && bus.start) begin
            op_n = bus.op;
        end
        case (state)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        2'd0:    next_state = RD;
                        2'd2:    next_state = WR;
                        default: next_state = IND;
                    endcase
                end
            end
            IND: begin
                if (phase_end) next_state = op_q[1] ? WR : RD;
            end
            RD, WR: begin
                if (phase_end) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        next_phase = (next_state == state && state != IDLE) ? phase + 4'd1 : 4'd0;
        case (next_state)
            IND:     next_mem_state = 2'd1;
            RD:      next_mem_state = 2'd0;
            WR:      next_mem_state = 2'd2;
            default: next_mem_state = 2'd3;
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            phase       <= 4'd0;
            op_q        <= 2'd0;
            mem_state_q <= 2'd3;
            m_control_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            load_data_q <= 16'h0000;
        end else begin
            state       <= next_state;
            phase       <= next_phase;
            op_q        <= op_n;
            mem_state_q <= next_mem_state;
            m_control_q <= (next_state == RD || next_state == WR) && op_n[0];
            busy_q      <= (next_state != IDLE);
            done_q      <= (next_state == RD || next_state == WR) && (next_phase == LAST);
            if (state == RD && phase_end) begin
                load_data_q <= bus.memout;
            end
        end
    end

    assign bus.mem_state = mem_state_q;
    assign bus.M_Control = m_control_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.load_data = load_data_q;

`ifdef MEMACCESS_CTRL_STATS_EN
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;

    // op_q still holds the finishing access during the done cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_cnt <= 16'h0000;
            wr_cnt <= 16'h0000;
        end else if (done_q) begin
            if (op_q[1]) wr_cnt <= wr_cnt + 16'd1;
            else         rd_cnt <= rd_cnt + 16'd1;
        end
    end

    assign bus.rd_count = rd_cnt;
    assign bus.wr_count = wr_cnt;
`else
    assign bus.rd_count = 16'h0000;
    assign bus.wr_count = 16'h0000;
`endif
endmodule

// File: tb/tb_memaccess_ctrl.sv
// Directed bench for memaccess_ctrl: one instance with DMEM_LAT=1 and one with DMEM_LAT=2.
module tb_memaccess_ctrl;
    logic clock;
    logic rst1;
    logic rst2;
    int   checks;
    int   errors;

    memaccess_ctrl_if b1 ();
    memaccess_ctrl_if b2 ();

    memaccess_ctrl #(.DMEM_LAT(1)) dut1 (.clock(clock), .reset(rst1), .bus(b1));
    memaccess_ctrl #(.DMEM_LAT(2)) dut2 (.clock(clock), .reset(rst2), .bus(b2));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [1:0] exp_ms2 [4];
    logic       exp_mc2 [4];
    logic       exp_dn2 [4];

    initial begin
        checks = 0;
        errors = 0;
        exp_ms2 = '{2'd1, 2'd1, 2'd0, 2'd0};
        exp_mc2 = '{1'b0, 1'b0, 1'b1, 1'b1};
        exp_dn2 = '{1'b0, 1'b0, 1'b0, 1'b1};

        b1.start = 1'b0; b1.op = 2'd0; b1.memout = 16'h0000;
        b2.start = 1'b0; b2.op = 2'd0; b2.memout = 16'h0000;
        rst1 = 1'b1;
        rst2 = 1'b1;
        tick();
        tick();
        chk("rst_mem_state", 16'(b1.mem_state), 16'd3);
        chk("rst_busy", 16'(b1.busy), 16'd0);
        chk("rst_done", 16'(b1.done), 16'd0);
        chk("rst_mctl", 16'(b1.M_Control), 16'd0);
        chk("rst_load_data", b1.load_data, 16'h0000);
        chk("rst_rd_count", b1.rd_count, 16'h0000);
        chk("rst_wr_count", b1.wr_count, 16'h0000);
        chk("rst2_mem_state", 16'(b2.mem_state), 16'd3);
        rst1 = 1'b0;
        rst2 = 1'b0;
        tick();

        // Direct read, DMEM_LAT=1
        b1.start = 1'b1; b1.op = 2'd0; b1.memout = 16'hBEEF;
        chk("ld_c0_mem_state", 16'(b1.mem_state), 16'd3);
        tick();
        b1.start = 1'b0;
        chk("ld_c1_mem_state", 16'(b1.mem_state), 16'd0);
        chk("ld_c1_done", 16'(b1.done), 16'd1);
        chk("ld_c1_busy", 16'(b1.busy), 16'd1);
        chk("ld_c1_mctl", 16'(b1.M_Control), 16'd0);
        tick();
        chk("ld_c2_mem_state", 16'(b1.mem_state), 16'd3);
        chk("ld_c2_done", 16'(b1.done), 16'd0);
        chk("ld_c2_load_data", b1.load_data, 16'hBEEF);
        chk("ld_c2_mctl", 16'(b1.M_Control), 16'd0);

        // Indirect read, DMEM_LAT=2
        b2.start = 1'b1; b2.op = 2'd1; b2.memout = 16'h1234;
        tick();
        b2.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ldi_c%0d_mem_state", i + 1), 16'(b2.mem_state), 16'(exp_ms2[i]));
            chk($sformatf("ldi_c%0d_mctl", i + 1), 16'(b2.M_Control), 16'(exp_mc2[i]));
            chk($sformatf("ldi_c%0d_done", i + 1), 16'(b2.done), 16'(exp_dn2[i]));
            tick();
        end
        chk("ldi_c5_mem_state", 16'(b2.mem_state), 16'd3);
        chk("ldi_c5_load_data", b2.load_data, 16'h1234);
        chk("ldi_c5_done", 16'(b2.done), 16'd0);

        // Indirect write, DMEM_LAT=1: load_data must keep BEEF
        b1.start = 1'b1; b1.op = 2'd3; b1.memout = 16'h5555;
        tick();
        b1.start = 1'b0;
        chk("sti_c1_mem_state", 16'(b1.mem_state), 16'd1);
        chk("sti_c1_mctl", 16'(b1.M_Control), 16'd0);
        chk("sti_c1_done", 16'(b1.done), 16'd0);
        tick();
        chk("sti_c2_mem_state", 16'(b1.mem_state), 16'd2);
        chk("sti_c2_mctl", 16'(b1.M_Control), 16'd1);
        chk("sti_c2_done", 16'(b1.done), 16'd1);
        tick();
        chk("sti_c3_mem_state", 16'(b1.mem_state), 16'd3);
        chk("sti_c3_load_data", b1.load_data, 16'hBEEF);

        // start held with op=2; op changed to 1 while busy must be ignored
        b1.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b1.op = 2'd2;
            tick();
            chk($sformatf("st_hold%0d_wr_mem_state", i), 16'(b1.mem_state), 16'd2);
            chk($sformatf("st_hold%0d_wr_done", i), 16'(b1.done), 16'd1);
            chk($sformatf("st_hold%0d_wr_mctl", i), 16'(b1.M_Control), 16'd0);
            b1.op = 2'd1;
            tick();
            chk($sformatf("st_hold%0d_idle_mem_state", i), 16'(b1.mem_state), 16'd3);
            chk($sformatf("st_hold%0d_idle_busy", i), 16'(b1.busy), 16'd0);
            chk($sformatf("st_hold%0d_idle_done", i), 16'(b1.done), 16'd0);
        end
        b1.start = 1'b0;
        b1.op = 2'd0;
        tick();
        chk("st_hold_end_mem_state", 16'(b1.mem_state), 16'd3);
        chk("st_hold_load_data", b1.load_data, 16'hBEEF);

`ifdef MEMACCESS_CTRL_STATS_EN
        chk("stats_rd_count", b1.rd_count, 16'd1);
        chk("stats_wr_count", b1.wr_count, 16'd4);
        dut1.wr_cnt = 16'hFFFF;
        b1.start = 1'b1; b1.op = 2'd2;
        tick();
        b1.start = 1'b0;
        chk("wrap_done", 16'(b1.done), 16'd1);
        tick();
        chk("wrap_wr_count", b1.wr_count, 16'h0000);
        chk("wrap_rd_count", b1.rd_count, 16'd1);
`else
        chk("nostats_rd_count", b1.rd_count, 16'h0000);
        chk("nostats_wr_count", b1.wr_count, 16'h0000);
`endif

        // Reset in the second IND cycle of an indirect read, DMEM_LAT=2
        b2.start = 1'b1; b2.op = 2'd1; b2.memout = 16'hCAFE;
        tick();
        b2.start = 1'b0;
        chk("abort_c1_mem_state", 16'(b2.mem_state), 16'd1);
        tick();
        chk("abort_c2_mem_state", 16'(b2.mem_state), 16'd1);
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        chk("abort_c3_mem_state", 16'(b2.mem_state), 16'd3);
        chk("abort_c3_busy", 16'(b2.busy), 16'd0);
        chk("abort_c3_done", 16'(b2.done), 16'd0);
        chk("abort_c3_load_data", b2.load_data, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("abort_after%0d_done", i), 16'(b2.done), 16'd0);
            chk($sformatf("abort_after%0d_mem_state", i), 16'(b2.mem_state), 16'd3);
        end
        chk("abort_final_load_data", b2.load_data, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
